resp_tx_framer: RTL
===================

# resp_tx_framer

Response framer in the REF_CLK domain between the system controller result sources and the UART transmit path. It captures register-read bytes and 16-bit ALU results into a small byte FIFO, splitting each ALU result into LSB then MSB. It then hands bytes one at a time to the UART transmitter, using a level-valid / Busy-acknowledge handshake with a timeout-and-retry.

## Interface

- DATA_WIDTH, 8, byte width; ALU result is 2*DATA_WIDTH
- FIFO_DEPTH, 4, byte FIFO entries; power of two, at least 4
- TIMEOUT, 64, REF_CLK cycles to wait for Busy before retrying
- REF_CLK  in  1  block clock
- SYNC_RST1  in  1  reset, asynchronous, active-low
- RdData  in  DATA_WIDTH  register-file read byte
- RdData_Valid  in  1  read strobe; rising edge pushes 1 byte
- ALU_OUT  in  2*DATA_WIDTH  ALU result
- OUT_VALID  in  1  ALU strobe; rising edge pushes 2 bytes
- Busy  in  1  UART TX busy, already 2-flop synchronized into REF_CLK
- TX_P_DATA  out  DATA_WIDTH  byte presented to the TX data synchronizer
- TX_D_VLD  out  1  level valid; held until Busy seen high
- resp_full  out  1  fewer than 2 free entries; controller holds off new commands
- drop_err  out  1  1-cycle pulse: a strobe was discarded for lack of space
- timeout_err  out  1  1-cycle pulse: Busy not seen within TIMEOUT; byte will be resent

## Operation

- **Strobe edge detection**
  - Registered copies of RdData_Valid and OUT_VALID; a push occurs on a 0->1 transition only.
  - A held-high strobe pushes once.
- **Push sizing**
  - needed = (rd_rise ? 1 : 0) + (alu_rise ? 2 : 0).
  - free = FIFO_DEPTH - count, where count is the value before this edge. A same-edge pop is not credited.
  - If needed <= free: write in the order RdData, ALU_OUT[DATA_WIDTH-1:0], ALU_OUT[2*DATA_WIDTH-1:DATA_WIDTH].
  - If needed > free: write nothing this edge and pulse drop_err. The two sources are never partially accepted.
- **FIFO**
  - Circular buffer; read/write pointers wrap modulo FIFO_DEPTH.
  - count is log2(FIFO_DEPTH)+1 bits; count_next = count + pushed - popped.
- **FSM states**
  - IDLE: if FIFO non-empty and Busy==0, pop into the hold register, drive TX_P_DATA, set TX_D_VLD=1, clear the timer, go to SEND.
  - SEND: TX_D_VLD=1 and TX_P_DATA held stable.
    - If Busy==1: TX_D_VLD=0, go to WAIT_DONE.
    - Else if timer==TIMEOUT-1: TX_D_VLD=0, pulse timeout_err, go to GAP.
    - Else increment the timer.
  - WAIT_DONE: wait for Busy==0, then go to IDLE.
  - GAP: hold TX_D_VLD=0 for 2 cycles, then re-present the same hold byte with TX_D_VLD=1, clear the timer, go to SEND. No pop occurs.
- **Ordering and retry**
  - Bytes leave in FIFO order.
  - A retried byte is never lost or duplicated in the FIFO.
- **Reset behaviour**
  - Reset asserted at any time, including mid-send, empties the FIFO and forces IDLE.
  - All outputs and registers go to their reset values immediately.

## Timing

- **Reset values:** TX_P_DATA=0, TX_D_VLD=0, resp_full=0, drop_err=0, timeout_err=0, state IDLE, count=0, strobe history registers=0.
- **Push latency:**
  - A strobe high at edge E (low at E-1) is written at E.
  - With the FIFO previously empty and Busy=0, TX_D_VLD and TX_P_DATA are high/valid after edge E+1.
- **Handshake:** TX_D_VLD falls at the first edge where Busy==1 is sampled in SEND.
- **Next byte:** issued at the first edge where Busy==0 is seen in IDLE, i.e. at least 2 edges after Busy falls.
- **Timeout:** TX_D_VLD stays high exactly TIMEOUT cycles, then is low for exactly 2 cycles (GAP) before re-assertion.
- **resp_full:** registered from count_next; asserted when FIFO_DEPTH - count_next < 2.
- **Error pulses:** drop_err and timeout_err are registered and exactly 1 cycle wide.
- **Simultaneous events:** a push and a pop on the same edge update count by +pushed-1 with no loss.

## Test plan

- **Single read:** RdData=0xA5 with RdData_Valid pulsed, Busy=0.
  - TX_P_DATA=0xA5, TX_D_VLD=1 two edges after the pulse.
  - Busy raised 3 cycles later -> TX_D_VLD=0 the next edge.
- **ALU split and ordering:** OUT_VALID rises with ALU_OUT=0x1234 and is held high 10 cycles.
  - Exactly 2 bytes sent, 0x34 then 0x12, each after Busy goes 1 then 0.
- **Simultaneous strobes:** RdData=0x55 and ALU_OUT=0xBEEF on the same edge.
  - Sent order: 0x55, 0xEF, 0xBE.
  - resp_full=1 after the push (1 free of 4).
- **Overflow:** Busy held 1, FIFO filled with 3 bytes, then an OUT_VALID rise.
  - drop_err pulses 1 cycle; count stays 3; later drain yields only the 3 original bytes.
- **Timeout retry:** TIMEOUT=8, Busy held 0.
  - TX_D_VLD high 8 cycles, timeout_err pulse, low 2 cycles, then high again with the same byte.
  - Busy=1 then 0 completes the byte; the next FIFO byte follows.
- **Reset mid-send:** SYNC_RST1 driven low during SEND with 2 bytes queued.
  - TX_D_VLD=0 asynchronously.
  - After release, no bytes are sent until a new strobe arrives.

Source files
------------

// File: rtl/resp_tx_framer.sv
// resp_tx_framer: captures register-read bytes and 16-bit ALU results into a
// small byte FIFO (ALU result split LSB then MSB) and hands bytes one at a time
// to the UART transmitter with a level-valid / Busy-acknowledge handshake,
// re-presenting a byte after TIMEOUT cycles without Busy.
module resp_tx_framer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic                    REF_CLK,
    input  logic                    SYNC_RST1,
    input  logic [DATA_WIDTH-1:0]   RdData,
    input  logic                    RdData_Valid,
    input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
    input  logic                    OUT_VALID,
    input  logic                    Busy,
    output logic [DATA_WIDTH-1:0]   TX_P_DATA,
    output logic                    TX_D_VLD,
    output logic                    resp_full,
    output logic                    drop_err,
    output logic                    timeout_err
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    // strobe history and edge detection
    logic                  r_rd_vld_q;
    logic                  r_alu_vld_q;
    logic                  w_rd_rise;
    logic                  w_alu_rise;

    // push sizing
    logic [1:0]            w_needed;
    logic [CW-1:0]         w_free;
    logic                  w_push_ok;
    logic                  w_drop;
    logic [1:0]            w_push_cnt;

    // FIFO storage and bookkeeping
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [AW-1:0]         w_wr_alu;
    logic [CW-1:0]         r_count;
    logic [CW-1:0]         w_count_next;
    logic                  w_pop;

    // transmit FSM
    state_t                r_state;
    state_t                w_state_next;
    logic [TW-1:0]         r_timer;
    logic [TW-1:0]         w_timer_next;
    logic                  r_gap;
    logic                  w_gap_next;
    logic [DATA_WIDTH-1:0] r_tx_data;
    logic [DATA_WIDTH-1:0] w_tx_data_next;
    logic                  r_tx_vld;
    logic                  w_tx_vld_next;
    logic                  w_tout_next;

    // registered status outputs
    logic                  r_full;
    logic                  r_drop;
    logic                  r_tout;

    assign TX_P_DATA   = r_tx_data;
    assign TX_D_VLD    = r_tx_vld;
    assign resp_full   = r_full;
    assign drop_err    = r_drop;
    assign timeout_err = r_tout;

    // Detect strobe rises and decide whether this edge's bytes fit as a whole.
    always_comb begin
        w_rd_rise  = RdData_Valid & ~r_rd_vld_q;
        w_alu_rise = OUT_VALID & ~r_alu_vld_q;
        // {alu, rd} read as a binary number is exactly 2*alu + 1*rd bytes
        w_needed   = {w_alu_rise, w_rd_rise};
        w_free     = CW'(FIFO_DEPTH) - r_count;
        w_push_ok  = (w_needed != 2'd0) && ({{(CW-2){1'b0}}, w_needed} <= w_free);
        w_drop     = (w_needed != 2'd0) && !w_push_ok;
        w_push_cnt = w_push_ok ? w_needed : 2'd0;
        w_wr_alu   = r_wr_ptr + AW'(w_rd_rise);
    end

    // Occupancy after this edge; a same-edge pop is applied here, not to free space.
    always_comb begin
        w_count_next = r_count + CW'(w_push_cnt) - CW'(w_pop);
    end

    // Write accepted bytes in order: read byte, ALU LSB, ALU MSB.
    always_ff @(posedge REF_CLK) begin
        if (w_push_ok) begin
            if (w_rd_rise) begin
                r_mem[r_wr_ptr] <= RdData;
            end
            if (w_alu_rise) begin
                r_mem[w_wr_alu]          <= ALU_OUT[DATA_WIDTH-1:0];
                r_mem[w_wr_alu + AW'(1)] <= ALU_OUT[2*DATA_WIDTH-1:DATA_WIDTH];
            end
        end
    end

    // Strobe history, FIFO pointers, occupancy and status pulses.
    always_ff @(posedge REF_CLK or negedge SYNC_RST1) begin
        if (!SYNC_RST1) begin
            r_rd_vld_q  <= 1'b0;
            r_alu_vld_q <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_full      <= 1'b0;
            r_drop      <= 1'b0;
        end else begin
            r_rd_vld_q  <= RdData_Valid;
            r_alu_vld_q <= OUT_VALID;
            r_wr_ptr    <= r_wr_ptr + AW'(w_push_cnt);
            r_rd_ptr    <= r_rd_ptr + AW'(w_pop);
            r_count     <= w_count_next;
            r_full      <= (w_count_next > CW'(FIFO_DEPTH - 2));
            r_drop      <= w_drop;
        end
    end

    // Transmit FSM next-state: pop, present, wait for Busy, or back off and retry.
    always_comb begin
        w_state_next   = r_state;
        w_timer_next   = r_timer;
        w_gap_next     = r_gap;
        w_tx_data_next = r_tx_data;
        w_tx_vld_next  = r_tx_vld;
        w_tout_next    = 1'b0;
        w_pop          = 1'b0;
        case (r_state)
            S_IDLE: begin
                if ((r_count != '0) && !Busy) begin
                    w_pop          = 1'b1;
                    w_tx_data_next = r_mem[r_rd_ptr];
                    w_tx_vld_next  = 1'b1;
                    w_timer_next   = '0;
                    w_state_next   = S_SEND;
                end
            end
            S_SEND: begin
                if (Busy) begin
                    w_tx_vld_next = 1'b0;
                    w_state_next  = S_WAIT_DONE;
                end else if (r_timer == TW'(TIMEOUT - 1)) begin
                    w_tx_vld_next = 1'b0;
                    w_tout_next   = 1'b1;
                    w_gap_next    = 1'b0;
                    w_state_next  = S_GAP;
                end else begin
                    w_timer_next = r_timer + TW'(1);
                end
            end
            S_WAIT_DONE: begin
                if (!Busy) begin
                    w_state_next = S_IDLE;
                end
            end
            S_GAP: begin
                // the hold register still owns the byte, so retry needs no pop
                if (r_gap) begin
                    w_tx_vld_next = 1'b1;
                    w_timer_next  = '0;
                    w_state_next  = S_SEND;
                end else begin
                    w_gap_next = 1'b1;
                end
            end
            default: begin
                w_state_next  = S_IDLE;
                w_tx_vld_next = 1'b0;
            end
        endcase
    end

    // Transmit FSM state, hold register and handshake outputs.
    always_ff @(posedge REF_CLK or negedge SYNC_RST1) begin
        if (!SYNC_RST1) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_gap     <= 1'b0;
            r_tx_data <= '0;
            r_tx_vld  <= 1'b0;
            r_tout    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_timer   <= w_timer_next;
            r_gap     <= w_gap_next;
            r_tx_data <= w_tx_data_next;
            r_tx_vld  <= w_tx_vld_next;
            r_tout    <= w_tout_next;
        end
    end

endmodule
